// File: rtl/ofs_fim_eth_chan_pkg.sv
// ---------------------------------------------------------------------------
// ofs_fim_eth_chan_pkg
//   Shared definitions for the per-channel HSSI Ethernet glue.
//   - Default widths of the RX data stream, sideband words and debug counters.
//   - t_rx_beat: one RX AXI-S beat at the default widths.
//   - t_sb_word: one sideband word at the default width.
//   - rx_beat_to_string: readable rendering of a beat for simulation logs.
// ---------------------------------------------------------------------------
package ofs_fim_eth_chan_pkg;

    localparam int DEF_DATA_W = 64;
    localparam int DEF_USER_W = 8;
    localparam int DEF_SB_W   = 32;
    localparam int DEF_CNT_W  = 32;

    typedef struct packed {
        logic [DEF_DATA_W-1:0]   tdata;
        logic [DEF_DATA_W/8-1:0] tkeep;
        logic                    tlast;
        logic [DEF_USER_W-1:0]   tuser;
    } t_rx_beat;

    typedef logic [DEF_SB_W-1:0] t_sb_word;

    function automatic string rx_beat_to_string(input t_rx_beat beat);
        return $sformatf("tdata=%h tkeep=%h tlast=%0b tuser=%h",
                         beat.tdata, beat.tkeep, beat.tlast, beat.tuser);
    endfunction

endpackage

// File: rtl/ofs_fim_eth_axis_skid.sv
// ---------------------------------------------------------------------------
// ofs_fim_eth_axis_skid
//   Two-entry (main + skid) AXI-S buffer with a registered upstream ready.
//   Full throughput with a 1-cycle latency when empty; the skid entry absorbs
//   the one beat that can arrive in the cycle after downstream stalls.
// Ports
//   clk, rst              clock, synchronous active-high reset
//   up_valid/up_ready     upstream handshake (up_ready is a flop output)
//   up_data [WIDTH]       upstream beat
//   dn_valid/dn_ready     downstream handshake
//   dn_data [WIDTH]       downstream beat, held while stalled
// ---------------------------------------------------------------------------
module ofs_fim_eth_axis_skid #(
    parameter int WIDTH = 81
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             up_valid,
    output logic             up_ready,
    input  logic [WIDTH-1:0] up_data,
    output logic             dn_valid,
    input  logic             dn_ready,
    output logic [WIDTH-1:0] dn_data
);

    logic             main_vld;
    logic             skid_vld;
    logic             rdy;
    logic [WIDTH-1:0] main_data;
    logic [WIDTH-1:0] skid_data;

    logic push;
    logic pop;
    logic main_open;
    logic main_vld_nxt;
    logic skid_vld_nxt;
    logic load_main;
    logic load_skid;

    // Upstream can only push while the skid is empty, so a full skid never
    // coincides with a push and main refills from skid first when it drains.
    always_comb begin
        push         = up_valid & rdy;
        pop          = main_vld & dn_ready;
        main_open    = ~main_vld | pop;
        main_vld_nxt = main_vld;
        skid_vld_nxt = skid_vld;
        load_main    = 1'b0;
        load_skid    = 1'b0;
        if (main_open) begin
            main_vld_nxt = skid_vld | push;
            load_main    = skid_vld | push;
            skid_vld_nxt = 1'b0;
        end else if (push) begin
            skid_vld_nxt = 1'b1;
            load_skid    = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            main_vld <= 1'b0;
            skid_vld <= 1'b0;
            rdy      <= 1'b0;
        end else begin
            main_vld <= main_vld_nxt;
            skid_vld <= skid_vld_nxt;
            rdy      <= ~skid_vld_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (load_main) begin
            main_data <= skid_vld ? skid_data : up_data;
        end
        if (load_skid) begin
            skid_data <= up_data;
        end
    end

    assign up_ready = rdy;
    assign dn_valid = main_vld;
    assign dn_data  = main_data;

endmodule

// File: rtl/ofs_fim_eth_rx_sb_channel.sv
// ---------------------------------------------------------------------------
// ofs_fim_eth_rx_sb_channel
//   Per-channel glue between the HSSI MAC and the AFU.
//   - RX data AXI-S (MAC->AFU) through a full-throughput skid buffer.
//   - SB RX (MAC->AFU) and SB TX (AFU->MAC) sideband: one register stage each.
//   - Debug: sticky last SB RX word, delivered-frame and errored-frame counters.
// Ports
//   clk, rst                        clock, synchronous active-high reset
//   mac_rx_*                        RX stream from MAC (tvalid/tready/tdata/tkeep/tlast/tuser)
//   afu_rx_*                        RX stream to AFU, same fields
//   mac_sb_rx_tvalid/tdata          SB RX from MAC    -> afu_sb_rx_tvalid/tdata
//   afu_sb_tx_tvalid/tdata          SB TX from AFU    -> mac_sb_tx_tvalid/tdata
//   sb_rx_status                    last SB RX word seen
//   rx_pkt_cnt, rx_err_cnt          frames delivered / frames with tuser[0] on tlast
// ---------------------------------------------------------------------------
module ofs_fim_eth_rx_sb_channel
    import ofs_fim_eth_chan_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int USER_W = DEF_USER_W,
    parameter int SB_W   = DEF_SB_W,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic                clk,
    input  logic                rst,

    input  logic                mac_rx_tvalid,
    output logic                mac_rx_tready,
    input  logic [DATA_W-1:0]   mac_rx_tdata,
    input  logic [DATA_W/8-1:0] mac_rx_tkeep,
    input  logic                mac_rx_tlast,
    input  logic [USER_W-1:0]   mac_rx_tuser,

    output logic                afu_rx_tvalid,
    input  logic                afu_rx_tready,
    output logic [DATA_W-1:0]   afu_rx_tdata,
    output logic [DATA_W/8-1:0] afu_rx_tkeep,
    output logic                afu_rx_tlast,
    output logic [USER_W-1:0]   afu_rx_tuser,

    input  logic                mac_sb_rx_tvalid,
    input  logic [SB_W-1:0]     mac_sb_rx_tdata,
    output logic                afu_sb_rx_tvalid,
    output logic [SB_W-1:0]     afu_sb_rx_tdata,

    input  logic                afu_sb_tx_tvalid,
    input  logic [SB_W-1:0]     afu_sb_tx_tdata,
    output logic                mac_sb_tx_tvalid,
    output logic [SB_W-1:0]     mac_sb_tx_tdata,

    output logic [SB_W-1:0]     sb_rx_status,
    output logic [CNT_W-1:0]    rx_pkt_cnt,
    output logic [CNT_W-1:0]    rx_err_cnt
);

    localparam int BEAT_W = DATA_W + DATA_W/8 + 1 + USER_W;

    logic [BEAT_W-1:0] rx_beat_in;
    logic [BEAT_W-1:0] rx_beat_out;

    assign rx_beat_in = {mac_rx_tdata, mac_rx_tkeep, mac_rx_tlast, mac_rx_tuser};

    ofs_fim_eth_axis_skid #(
        .WIDTH (BEAT_W)
    ) u_rx_skid (
        .clk      (clk),
        .rst      (rst),
        .up_valid (mac_rx_tvalid),
        .up_ready (mac_rx_tready),
        .up_data  (rx_beat_in),
        .dn_valid (afu_rx_tvalid),
        .dn_ready (afu_rx_tready),
        .dn_data  (rx_beat_out)
    );

    assign {afu_rx_tdata, afu_rx_tkeep, afu_rx_tlast, afu_rx_tuser} = rx_beat_out;

    // ---- Sideband stage p1 ----
    logic            sb_rx_vld_p1;
    logic [SB_W-1:0] sb_rx_data_p1;
    logic            sb_tx_vld_p1;
    logic [SB_W-1:0] sb_tx_data_p1;
    logic [SB_W-1:0] sb_status;

    always_ff @(posedge clk) begin
        if (rst) begin
            sb_rx_vld_p1 <= 1'b0;
            sb_tx_vld_p1 <= 1'b0;
            sb_status    <= '0;
        end else begin
            sb_rx_vld_p1 <= mac_sb_rx_tvalid;
            sb_tx_vld_p1 <= afu_sb_tx_tvalid;
            if (mac_sb_rx_tvalid) begin
                sb_status <= mac_sb_rx_tdata;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (mac_sb_rx_tvalid) begin
            sb_rx_data_p1 <= mac_sb_rx_tdata;
        end
        if (afu_sb_tx_tvalid) begin
            sb_tx_data_p1 <= afu_sb_tx_tdata;
        end
    end

    assign afu_sb_rx_tvalid = sb_rx_vld_p1;
    assign afu_sb_rx_tdata  = sb_rx_data_p1;
    assign mac_sb_tx_tvalid = sb_tx_vld_p1;
    assign mac_sb_tx_tdata  = sb_tx_data_p1;
    assign sb_rx_status     = sb_status;

    // Frames are counted where the AFU actually accepts the tlast beat.
    logic frame_done;
    assign frame_done = afu_rx_tvalid & afu_rx_tready & afu_rx_tlast;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_pkt_cnt <= '0;
            rx_err_cnt <= '0;
        end else if (frame_done) begin
            rx_pkt_cnt <= rx_pkt_cnt + CNT_W'(1);
            if (afu_rx_tuser[0]) begin
                rx_err_cnt <= rx_err_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_ofs_fim_eth_rx_sb_channel.sv
// ---------------------------------------------------------------------------
// tb_ofs_fim_eth_rx_sb_channel
//   Randomized bench with a queue-based reference model of the channel:
//   beats accepted from the MAC are queued and must appear at the AFU in
//   order and bit-exact; the buffer holds at most two beats; counters and
//   sideband are modelled from the stream-level rules.
// ---------------------------------------------------------------------------
module tb_ofs_fim_eth_rx_sb_channel;

    localparam int DATA_W = 64;
    localparam int USER_W = 8;
    localparam int SB_W   = 32;
    localparam int CNT_W  = 32;
    localparam int BEAT_W = DATA_W + DATA_W/8 + 1 + USER_W;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                mac_rx_tvalid = 1'b0;
    logic                mac_rx_tready;
    logic [DATA_W-1:0]   mac_rx_tdata = '0;
    logic [DATA_W/8-1:0] mac_rx_tkeep = '0;
    logic                mac_rx_tlast = 1'b0;
    logic [USER_W-1:0]   mac_rx_tuser = '0;
    logic                afu_rx_tvalid;
    logic                afu_rx_tready = 1'b0;
    logic [DATA_W-1:0]   afu_rx_tdata;
    logic [DATA_W/8-1:0] afu_rx_tkeep;
    logic                afu_rx_tlast;
    logic [USER_W-1:0]   afu_rx_tuser;
    logic                mac_sb_rx_tvalid = 1'b0;
    logic [SB_W-1:0]     mac_sb_rx_tdata = '0;
    logic                afu_sb_rx_tvalid;
    logic [SB_W-1:0]     afu_sb_rx_tdata;
    logic                afu_sb_tx_tvalid = 1'b0;
    logic [SB_W-1:0]     afu_sb_tx_tdata = '0;
    logic                mac_sb_tx_tvalid;
    logic [SB_W-1:0]     mac_sb_tx_tdata;
    logic [SB_W-1:0]     sb_rx_status;
    logic [CNT_W-1:0]    rx_pkt_cnt;
    logic [CNT_W-1:0]    rx_err_cnt;

    ofs_fim_eth_rx_sb_channel #(
        .DATA_W (DATA_W),
        .USER_W (USER_W),
        .SB_W   (SB_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .mac_rx_tvalid    (mac_rx_tvalid),
        .mac_rx_tready    (mac_rx_tready),
        .mac_rx_tdata     (mac_rx_tdata),
        .mac_rx_tkeep     (mac_rx_tkeep),
        .mac_rx_tlast     (mac_rx_tlast),
        .mac_rx_tuser     (mac_rx_tuser),
        .afu_rx_tvalid    (afu_rx_tvalid),
        .afu_rx_tready    (afu_rx_tready),
        .afu_rx_tdata     (afu_rx_tdata),
        .afu_rx_tkeep     (afu_rx_tkeep),
        .afu_rx_tlast     (afu_rx_tlast),
        .afu_rx_tuser     (afu_rx_tuser),
        .mac_sb_rx_tvalid (mac_sb_rx_tvalid),
        .mac_sb_rx_tdata  (mac_sb_rx_tdata),
        .afu_sb_rx_tvalid (afu_sb_rx_tvalid),
        .afu_sb_rx_tdata  (afu_sb_rx_tdata),
        .afu_sb_tx_tvalid (afu_sb_tx_tvalid),
        .afu_sb_tx_tdata  (afu_sb_tx_tdata),
        .mac_sb_tx_tvalid (mac_sb_tx_tvalid),
        .mac_sb_tx_tdata  (mac_sb_tx_tdata),
        .sb_rx_status     (sb_rx_status),
        .rx_pkt_cnt       (rx_pkt_cnt),
        .rx_err_cnt       (rx_err_cnt)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state
    logic [BEAT_W-1:0] exp_q[$];
    int                occ;
    int                model_pkt;
    int                model_err;
    int                sent;
    bit                pend;
    logic [BEAT_W-1:0] hold_beat;
    bit                sb_rx_prev_v;
    logic [SB_W-1:0]   sb_rx_prev_d;
    bit                sb_tx_prev_v;
    logic [SB_W-1:0]   sb_tx_prev_d;
    logic [SB_W-1:0]   status_model;

    task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic void model_clear();
        exp_q.delete();
        occ          = 0;
        model_pkt    = 0;
        model_err    = 0;
        sent         = 0;
        pend         = 0;
        sb_rx_prev_v = 0;
        sb_tx_prev_v = 0;
        status_model = '0;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst              = 1'b1;
        mac_rx_tvalid    = 1'b0;
        afu_rx_tready    = 1'b0;
        mac_sb_rx_tvalid = 1'b0;
        afu_sb_tx_tvalid = 1'b0;
        @(negedge clk);
        check_val("rst_afu_tvalid", afu_rx_tvalid, 0);
        check_val("rst_mac_tready", mac_rx_tready, 0);
        check_val("rst_sb_rx_v", afu_sb_rx_tvalid, 0);
        check_val("rst_sb_tx_v", mac_sb_tx_tvalid, 0);
        check_val("rst_pkt_cnt", rx_pkt_cnt, 0);
        check_val("rst_err_cnt", rx_err_cnt, 0);
        check_val("rst_sb_status", sb_rx_status, 0);
        rst = 1'b0;
        model_clear();
    endtask

    // One clock: check outputs against the model, drive inputs, then advance
    // the model by the transfers that the coming rising edge will perform.
    task automatic tick(input bit want_valid, input bit ar, input int last_every, input bit err_on_last,
                        input bit srv, input logic [SB_W-1:0] srd, input bit stv, input logic [SB_W-1:0] std);
        logic [BEAT_W-1:0] f;
        logic [BEAT_W-1:0] obs;
        bit                lst;
        @(negedge clk);
        obs = {afu_rx_tdata, afu_rx_tkeep, afu_rx_tlast, afu_rx_tuser};
        check_val("mac_tready", mac_rx_tready, (occ < 2) ? 1 : 0);
        check_val("afu_tvalid", afu_rx_tvalid, (occ > 0) ? 1 : 0);
        if (afu_rx_tvalid && exp_q.size() > 0) check_val("afu_beat", obs, exp_q[0]);
        check_val("pkt_cnt", rx_pkt_cnt, model_pkt);
        check_val("err_cnt", rx_err_cnt, model_err);
        check_val("sb_rx_v", afu_sb_rx_tvalid, sb_rx_prev_v);
        if (sb_rx_prev_v) check_val("sb_rx_d", afu_sb_rx_tdata, sb_rx_prev_d);
        check_val("sb_tx_v", mac_sb_tx_tvalid, sb_tx_prev_v);
        if (sb_tx_prev_v) check_val("sb_tx_d", mac_sb_tx_tdata, sb_tx_prev_d);
        check_val("sb_status", sb_rx_status, status_model);

        if (!pend && want_valid) begin
            lst       = ((sent + 1) % last_every) == 0;
            hold_beat = {$urandom(), $urandom(), 8'($urandom()), lst,
                         7'($urandom()), lst & err_on_last};
            pend      = 1;
        end
        mac_rx_tvalid = pend;
        {mac_rx_tdata, mac_rx_tkeep, mac_rx_tlast, mac_rx_tuser} = hold_beat;
        afu_rx_tready    = ar;
        mac_sb_rx_tvalid = srv;
        mac_sb_rx_tdata  = srd;
        afu_sb_tx_tvalid = stv;
        afu_sb_tx_tdata  = std;

        if (afu_rx_tvalid && ar) begin
            if (exp_q.size() == 0) begin
                check_val("afu_extra_beat", 1, 0);
            end else begin
                f = exp_q.pop_front();
                occ--;
                if (f[USER_W]) begin
                    model_pkt++;
                    if (f[0]) model_err++;
                end
            end
        end
        if (pend && mac_rx_tready) begin
            exp_q.push_back(hold_beat);
            occ++;
            sent++;
            pend = 0;
        end
        sb_rx_prev_v = srv;
        sb_rx_prev_d = srd;
        sb_tx_prev_v = stv;
        sb_tx_prev_d = std;
        if (srv) status_model = srd;
    endtask

    task automatic tick_rx(input bit want_valid, input bit ar, input int last_every, input bit err_on_last);
        tick(want_valid, ar, last_every, err_on_last,
             bit'($urandom_range(1, 0)), $urandom(), bit'($urandom_range(1, 0)), $urandom());
    endtask

    task automatic drain();
        int n = 0;
        while ((occ > 0 || pend) && n < 50) begin
            tick_rx(0, 1, 1000000, 0);
            n++;
        end
        check_val("drain_timeout", (occ > 0 || pend) ? 1 : 0, 0);
        tick_rx(0, 1, 1000000, 0);
    endtask

    initial begin
        int n;
        int base;
        model_clear();

        // 1: 8-beat clean frame, AFU always ready
        do_reset();
        for (int i = 0; i < 8; i++) tick_rx(1, 1, 8, 0);
        drain();
        check_val("t1_pkt", rx_pkt_cnt, 1);
        check_val("t1_err", rx_err_cnt, 0);
        check_val("t1_sent", sent, 8);

        // 2: AFU stalled while MAC streams -> only two beats buffered
        do_reset();
        for (int i = 0; i < 6; i++) tick_rx(1, 0, 4, 0);
        check_val("t2_accepted", sent, 2);
        check_val("t2_tready_low", mac_rx_tready, 0);
        for (int i = 0; i < 6; i++) tick_rx(1, 1, 4, 0);
        drain();
        check_val("t2_pkt", rx_pkt_cnt, model_pkt);

        // 3: random handshakes over 1000 beats, tlast every 5
        do_reset();
        n = 0;
        while (sent < 1000 && n < 20000) begin
            tick_rx((sent + (pend ? 1 : 0)) < 1000 && ($urandom_range(1, 0) == 1),
                    $urandom_range(1, 0) == 1, 5, 0);
            n++;
        end
        check_val("t3_budget", sent, 1000);
        drain();
        check_val("t3_pkt", rx_pkt_cnt, 200);
        check_val("t3_err", rx_err_cnt, 0);

        // 4: errored frame
        do_reset();
        for (int i = 0; i < 3; i++) tick_rx(1, 1, 3, 1);
        drain();
        check_val("t4_err", rx_err_cnt, 1);
        check_val("t4_pkt", rx_pkt_cnt, 1);

        // 5: sideband forwarding and sticky status
        do_reset();
        tick(0, 1, 5, 0, 1, 32'hA5A5_0001, 1, 32'h0000_0003);
        tick(0, 1, 5, 0, 0, 32'h1234_5678, 0, 32'h8765_4321);
        check_val("t5_sb_rx_v", afu_sb_rx_tvalid, 1);
        check_val("t5_sb_rx_d", afu_sb_rx_tdata, 32'hA5A5_0001);
        check_val("t5_sb_tx_v", mac_sb_tx_tvalid, 1);
        check_val("t5_sb_tx_d", mac_sb_tx_tdata, 32'h0000_0003);
        for (int i = 0; i < 3; i++) tick(0, 1, 5, 0, 0, $urandom(), 0, $urandom());
        check_val("t5_status", sb_rx_status, 32'hA5A5_0001);
        check_val("t5_sb_rx_idle", afu_sb_rx_tvalid, 0);

        // 6: reset mid-frame with skid full, after one delivered frame
        do_reset();
        for (int i = 0; i < 2; i++) tick_rx(1, 1, 2, 0);
        drain();
        base = 0;
        while (occ < 2 && base < 20) begin
            tick_rx(1, 0, 100, 0);
            base++;
        end
        check_val("t6_full", occ, 2);
        check_val("t6_pkt_before", rx_pkt_cnt, 1);
        do_reset();
        tick_rx(0, 1, 100, 0);
        check_val("t6_tready_after", mac_rx_tready, 1);
        check_val("t6_no_beat", afu_rx_tvalid, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
